// File: rtl/data_mem_if_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_if_if
// Brief    : Word-lane data bus between the access sequencer (master) and
//            the external data memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_if_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_if
// Brief    : Data-memory access sequencer. Aligns a byte-addressed request
//            onto 32-bit bus lanes, splits word-crossing accesses into two
//            beats and merges split reads back into LSB-aligned data.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_if #(
  parameter int MAX_WAIT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               req_valid,
  input  logic               mem_rw_mode,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_write_data,
  input  logic [3:0]         mem_byte_en,
  output logic               busy,
  output logic               resp_valid,
  output logic [31:0]        rd_data,
  output logic               err,
  data_mem_if_if.master      bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4
  } state_t;

  state_t      state;
  logic        req_rw;
  logic [1:0]  req_off;
  logic [3:0]  req_be;
  logic        split;
  logic [3:0]  hi_be;
  logic [31:0] hi_wdata;
  logic [31:0] lo_data;
  logic [7:0]  wait_cnt;

  logic [7:0]  acc_sh_be;
  logic [63:0] acc_sh_d;
  logic        acc_legal;

  // Shift the incoming request onto bus lanes; the upper half feeds beat 1.
  always_comb begin
    acc_sh_be = {4'b0000, mem_byte_en} << mem_addr[1:0];
    acc_sh_d  = {32'h0, mem_write_data} << {mem_addr[1:0], 3'b000};
    acc_legal = (mem_byte_en == 4'b0001) || (mem_byte_en == 4'b0011) ||
                (mem_byte_en == 4'b1111);
  end

  // The core must stall in the very cycle it raises a request.
  always_comb begin
    busy = (state != IDLE) || req_valid;
  end

  // Undo the lane shift of a (possibly two-beat) read and zero unused bytes.
  function automatic logic [31:0] merge_read(input logic [31:0] hi,
                                             input logic [31:0] lo,
                                             input logic [1:0]  off,
                                             input logic [3:0]  be);
    logic [63:0] joined;
    logic [31:0] mask;
    joined = {hi, lo} >> {off, 3'b000};
    mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return joined[31:0] & mask;
  endfunction

  // Sequencer: one or two bus beats per request, registered bus and response outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      req_rw        <= 1'b0;
      req_off       <= 2'b00;
      req_be        <= 4'b0000;
      split         <= 1'b0;
      hi_be         <= 4'b0000;
      hi_wdata      <= 32'h0;
      lo_data       <= 32'h0;
      wait_cnt      <= 8'h00;
      resp_valid    <= 1'b0;
      rd_data       <= 32'h0;
      err           <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'h0;
      bus.bus_wdata <= 32'h0;
      bus.bus_be    <= 4'b0000;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_rw   <= mem_rw_mode;
            req_off  <= mem_addr[1:0];
            req_be   <= mem_byte_en;
            split    <= |acc_sh_be[7:4];
            hi_be    <= acc_sh_be[7:4];
            hi_wdata <= acc_sh_d[63:32];
            if (!acc_legal) begin
              // Rejected without touching the bus.
              resp_valid <= 1'b1;
              err        <= 1'b1;
              rd_data    <= 32'h0;
            end else begin
              state         <= REQ0;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= mem_rw_mode;
              bus.bus_addr  <= {mem_addr[31:2], 2'b00};
              bus.bus_be    <= acc_sh_be[3:0];
              bus.bus_wdata <= acc_sh_d[31:0];
            end
          end
        end

        REQ0, REQ1: begin
          // A response in the grant cycle itself is not looked at.
          if (bus.bus_gnt) begin
            bus.bus_req <= 1'b0;
            wait_cnt    <= 8'h00;
            state       <= (state == REQ0) ? WAIT0 : WAIT1;
          end
        end

        WAIT0: begin
          if (bus.bus_rvalid) begin
            lo_data <= bus.bus_rdata;
            if (split) begin
              state         <= REQ1;
              bus.bus_req   <= 1'b1;
              bus.bus_addr  <= bus.bus_addr + 32'd4;
              bus.bus_be    <= hi_be;
              bus.bus_wdata <= hi_wdata;
            end else begin
              state      <= IDLE;
              resp_valid <= 1'b1;
              err        <= 1'b0;
              rd_data    <= req_rw ? 32'h0 :
                            merge_read(32'h0, bus.bus_rdata, req_off, req_be);
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state      <= IDLE;
            resp_valid <= 1'b1;
            err        <= 1'b1;
            rd_data    <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'h01;
          end
        end

        WAIT1: begin
          if (bus.bus_rvalid) begin
            state      <= IDLE;
            resp_valid <= 1'b1;
            err        <= 1'b0;
            rd_data    <= req_rw ? 32'h0 :
                          merge_read(bus.bus_rdata, lo_data, req_off, req_be);
          end else if (wait_cnt == WAIT_LAST) begin
            state      <= IDLE;
            resp_valid <= 1'b1;
            err        <= 1'b1;
            rd_data    <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'h01;
          end
        end

        default: begin
          state       <= IDLE;
          bus.bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_if
// Brief    : Directed self-checking bench for data_mem_if.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_mem_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_rw_mode = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_write_data = 32'h0;
  logic [3:0]  mem_byte_en = 4'h0;
  logic        busy;
  logic        resp_valid;
  logic [31:0] rd_data;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  data_mem_if_if bus_i ();

  data_mem_if #(.MAX_WAIT(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .req_valid      (req_valid),
    .mem_rw_mode    (mem_rw_mode),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_byte_en    (mem_byte_en),
    .busy           (busy),
    .resp_valid     (resp_valid),
    .rd_data        (rd_data),
    .err            (err),
    .bus            (bus_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; busy must follow req_valid combinationally.
  task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    req_valid      = 1'b1;
    mem_rw_mode    = rw;
    mem_addr       = a;
    mem_write_data = d;
    mem_byte_en    = be;
    #1;
    check_eq("busy_on_req", 32'(busy), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Check one bus beat, grant it after gnt_delay cycles, answer the next cycle.
  task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic ewe, input int gnt_delay,
                      input logic [31:0] rdata);
    for (int i = 0; i < gnt_delay; i++) tick();
    check_eq({tag, "_req"},   32'(bus_i.bus_req), 32'd1);
    check_eq({tag, "_addr"},  bus_i.bus_addr, ea);
    check_eq({tag, "_be"},    32'(bus_i.bus_be), 32'(ebe));
    check_eq({tag, "_we"},    32'(bus_i.bus_we), 32'(ewe));
    if (ewe) check_eq({tag, "_wdata"}, bus_i.bus_wdata, ewd);
    // Response in the grant cycle carries junk and must be ignored.
    bus_i.bus_gnt    = 1'b1;
    bus_i.bus_rvalid = 1'b1;
    bus_i.bus_rdata  = 32'hBAD0BAD0;
    tick();
    bus_i.bus_gnt    = 1'b0;
    bus_i.bus_rvalid = 1'b0;
    check_eq({tag, "_req_drop"}, 32'(bus_i.bus_req), 32'd0);
    check_eq({tag, "_no_early_resp"}, 32'(resp_valid), 32'd0);
    bus_i.bus_rvalid = 1'b1;
    bus_i.bus_rdata  = rdata;
    tick();
    bus_i.bus_rvalid = 1'b0;
    bus_i.bus_rdata  = 32'h0;
  endtask

  // Response pulse, then a single-cycle pulse with held data, then idle.
  task automatic check_resp(input string tag, input logic exp_err, input logic [31:0] exp_rd);
    check_eq({tag, "_resp"},  32'(resp_valid), 32'd1);
    check_eq({tag, "_err"},   32'(err), 32'(exp_err));
    check_eq({tag, "_rdata"}, rd_data, exp_rd);
    tick();
    check_eq({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_hold"},  rd_data, exp_rd);
    check_eq({tag, "_idle"},  32'(busy), 32'd0);
  endtask

  initial begin
    bus_i.bus_gnt    = 1'b0;
    bus_i.bus_rvalid = 1'b0;
    bus_i.bus_rdata  = 32'h0;
    tick();
    tick();
    check_eq("rst_bus_req", 32'(bus_i.bus_req), 32'd0);
    check_eq("rst_resp",    32'(resp_valid), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'h0);
    check_eq("rst_err",     32'(err), 32'd0);
    check_eq("rst_busy",    32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Aligned word write: single beat.
    issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
    beat("wr_word", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b1, 0, 32'h0);
    check_resp("wr_word", 1'b0, 32'h0);

    // Misaligned halfword write crossing a word.
    issue(1'b1, 32'h0000_0103, 32'h0000_ABCD, 4'b0011);
    beat("wr_hw_b0", 32'h0000_0100, 4'b1000, 32'hCD00_0000, 1'b1, 0, 32'h0);
    beat("wr_hw_b1", 32'h0000_0104, 4'b0001, 32'h0000_00AB, 1'b1, 0, 32'h0);
    check_resp("wr_hw", 1'b0, 32'h0);

    // Misaligned word read: two beats merged.
    issue(1'b0, 32'h0000_00FE, 32'h0, 4'b1111);
    beat("rd_w_b0", 32'h0000_00FC, 4'b1100, 32'h0, 1'b0, 0, 32'h1122_3344);
    beat("rd_w_b1", 32'h0000_0100, 4'b0011, 32'h0, 1'b0, 1, 32'h5566_7788);
    check_resp("rd_w", 1'b0, 32'h7788_1122);

    // Byte read with a delayed grant.
    issue(1'b0, 32'h0000_0201, 32'h0, 4'b0001);
    beat("rd_b", 32'h0000_0200, 4'b0010, 32'h0, 1'b0, 2, 32'hAABB_CCDD);
    check_resp("rd_b", 1'b0, 32'h0000_00CC);

    // Address wrap on the second beat.
    issue(1'b0, 32'hFFFF_FFFE, 32'h0, 4'b1111);
    beat("wrap_b0", 32'hFFFF_FFFC, 4'b1100, 32'h0, 1'b0, 0, 32'h1234_5678);
    beat("wrap_b1", 32'h0000_0000, 4'b0011, 32'h0, 1'b0, 0, 32'h9ABC_DEF0);
    check_resp("wrap", 1'b0, 32'hDEF0_1234);

    // Illegal mask: no bus activity, error next cycle.
    issue(1'b0, 32'h0000_0300, 32'h0, 4'b0101);
    check_eq("illegal_no_req", 32'(bus_i.bus_req), 32'd0);
    check_resp("illegal", 1'b1, 32'h0);

    // Timeout: grant, then no response for MAX_WAIT (4) wait cycles.
    issue(1'b0, 32'h0000_0300, 32'h0, 4'b1111);
    check_eq("to_req", 32'(bus_i.bus_req), 32'd1);
    bus_i.bus_gnt = 1'b1;
    tick();
    bus_i.bus_gnt = 1'b0;
    tick();
    tick();
    tick();
    check_eq("to_not_yet", 32'(resp_valid), 32'd0);
    check_eq("to_busy",    32'(busy), 32'd1);
    tick();
    check_resp("timeout", 1'b1, 32'h0);

    // Asynchronous reset while waiting on the second beat.
    issue(1'b0, 32'h0000_0401, 32'h0, 4'b1111);
    beat("rst_b0", 32'h0000_0400, 4'b1110, 32'h0, 1'b0, 0, 32'h0102_0304);
    check_eq("rst_b1_addr", bus_i.bus_addr, 32'h0000_0404);
    check_eq("rst_b1_be",   32'(bus_i.bus_be), 32'h1);
    bus_i.bus_gnt = 1'b1;
    tick();
    bus_i.bus_gnt = 1'b0;
    check_eq("wait1_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_req",  32'(bus_i.bus_req), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_resp", 32'(resp_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_if.md
Name: data_mem_if

Overview:
- Data-memory access sequencer between the load/store units and the external data bus.
- Takes one byte-addressed request per transaction, aligns data and byte enables to bus word lanes, and issues one or two bus beats.
- Splits any access that crosses a 32-bit word boundary into two beats. For reads, merges the two beats back into LSB-aligned read data.
- Drives a busy signal that the core uses to stall the PC.

Parameters:
- MAX_WAIT, 255: cycles allowed in a wait state without bus_rvalid before the transaction aborts with err. Range 1..255.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request strobe; sampled only in IDLE
- mem_rw_mode  in  1  1 = write, 0 = read
- mem_addr  in  32  byte address; may be misaligned
- mem_write_data  in  32  store data, LSB-aligned (unshifted)
- mem_byte_en  in  4  size mask, LSB-aligned; legal values 0001, 0011, 1111
- busy  out  1  stall request to the core
- resp_valid  out  1  one-cycle completion pulse
- rd_data  out  32  read data, LSB-aligned; unused bytes are zero; no sign extension
- err  out  1  valid only with resp_valid; illegal mask or timeout
- bus_req  out  1  bus beat request
- bus_we  out  1  beat is a write
- bus_addr  out  32  word-aligned beat address (bits [1:0] = 00)
- bus_wdata  out  32  lane-aligned write data
- bus_be  out  4  lane byte enables
- bus_gnt  in  1  beat accepted in the cycle bus_req && bus_gnt
- bus_rvalid  in  1  beat completion (read data or write ack)
- bus_rdata  in  32  read beat data

Behaviour:
- Reset: all outputs 0, FSM goes to IDLE, wait counter cleared. Asynchronous reset mid-transaction drops bus_req immediately; the in-flight beat is abandoned.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1.
- busy = (state != IDLE) || req_valid. This is combinational, so the core stalls in the same cycle it requests.
- Request accept (IDLE && req_valid):
  - Latch rw, addr, data, mask.
  - off = addr[1:0]; sh_be = {4'b0, be} << off (8 bits); sh_d = {32'b0, data} << 8*off (64 bits).
  - split = |sh_be[7:4].
  - Illegal mask (any value other than 0001/0011/1111): no bus activity; next cycle resp_valid = 1, err = 1; remain in IDLE.
  - Otherwise go to REQ0.
- REQ0:
  - Drive bus_req = 1, bus_addr = {addr[31:2], 2'b00}, bus_be = sh_be[3:0], bus_wdata = sh_d[31:0], bus_we = rw.
  - Hold all bus outputs until bus_gnt, then go to WAIT0.
- WAIT0:
  - bus_req = 0; the counter increments each cycle.
  - On bus_rvalid, capture bus_rdata as lo. If split, go to REQ1; otherwise finish.
  - A bus_rvalid in the grant cycle itself is ignored; the earliest valid response is the cycle after grant.
- REQ1 / WAIT1:
  - Same as REQ0 / WAIT0 with bus_addr = {addr[31:2], 2'b00} + 4 (wraps modulo 2^32), bus_be = sh_be[7:4], bus_wdata = sh_d[63:32].
  - Capture hi on bus_rvalid.
- Finish:
  - Next cycle: resp_valid = 1, err = 0, state = IDLE.
  - For reads: rd_data = ({hi, lo} >> 8*off)[31:0] masked to be, with hi = 0 if not split.
  - For writes: rd_data = 0.
  - A new req_valid may be accepted in the same cycle that resp_valid is high.
- Timeout:
  - Counter is reset on entry to each WAIT state.
  - If the counter reaches MAX_WAIT without bus_rvalid: resp_valid = 1 and err = 1 next cycle, state = IDLE, any second beat skipped.
- rd_data and err hold their values until the next resp_valid. resp_valid is never high for two consecutive cycles from a single request.

Test Plan:
- Aligned word write: addr=0x100, data=0xDEADBEEF, be=1111, gnt same cycle, rvalid +1 -> one beat: bus_addr=0x100, be=1111, wdata=0xDEADBEEF; resp_valid at cycle 3, err=0.
- Misaligned halfword write: addr=0x103, data=0x0000ABCD, be=0011 -> beat0: addr=0x100, be=1000, wdata=0xCD000000; beat1: addr=0x104, be=0001, wdata=0x000000AB.
- Misaligned word read: addr=0x0FE, be=1111; rdata0=0x11223344, rdata1=0x55667788 -> rd_data=0x77881122, two beats, err=0.
- Byte read at 0x201 with rdata=0xAABBCCDD -> bus_be=0010, rd_data=0x000000CC.
- Wrap and timeout: addr=0xFFFFFFFE, be=1111 -> beat1 addr=0x00000000. Separately, MAX_WAIT=4 with no rvalid -> resp_valid and err=1 after 4 wait cycles, then IDLE.
- Illegal mask 0101 -> no bus_req, resp_valid=1 with err=1 next cycle. i_rst asserted in WAIT1 -> bus_req=0, busy=0 (req_valid low), state IDLE immediately.
